// File: rtl/zmod_scope_cfg_seq.sv
// Zmod Scope front-end configuration sequencer: AD9648 3-wire SPI init
// table followed by one-at-a-time latching relay pulses (mclk domain).
module zmod_scope_cfg_seq #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned NUM_WORDS   = 4,
  parameter logic [24*NUM_WORDS-1:0] INIT_WORDS =
    {24'h00FF01, 24'h001401, 24'h000800, 24'h00003C},
  parameter int unsigned RELAY_PULSE = 1250000,
  parameter int unsigned RELAY_GAP   = 125000
) (
  input  logic mclk,
  input  logic ext_rst,
  input  logic start,
  input  logic relay_req,
  input  logic ch1_ac,
  input  logic ch2_ac,
  input  logic ch1_hg,
  input  logic ch2_hg,
  output logic busy,
  output logic cfg_done,
  output logic csb,
  output logic sclk,
  output logic sdio,
  output logic sc1_ac_h,
  output logic sc1_ac_l,
  output logic sc2_ac_h,
  output logic sc2_ac_l,
  output logic sc1_gain_h,
  output logic sc1_gain_l,
  output logic sc2_gain_h,
  output logic sc2_gain_l,
  output logic com_sc_h,
  output logic com_sc_l
);

  localparam int unsigned CMAX0 =
    (RELAY_PULSE > RELAY_GAP) ? RELAY_PULSE : RELAY_GAP;
  localparam int unsigned CMAX = (CMAX0 > CLK_DIV) ? CMAX0 : CLK_DIV;
  localparam int unsigned CW = $clog2(CMAX + 1);
  localparam int unsigned WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(RELAY_PULSE - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(RELAY_GAP - 1);
  localparam logic [WW-1:0] WORD_LAST  = WW'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, SHIFT, CS_HOLD, CS_GAP, RLY_PULSE, RLY_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bit_q, bit_d;
  logic          half_q, half_d;
  logic [WW-1:0] word_q, word_d;
  logic [1:0]    rly_q, rly_d;
  logic          full_q, full_d;
  logic [3:0]    set_q, set_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          csb_q, csb_d;
  logic          sclk_q, sclk_d;
  logic          sdio_q, sdio_d;
  logic [3:0]    h_q, h_d, l_q, l_d;
  logic          comh_q, comh_d, coml_q, coml_d;
  logic [23:0]   word_bits;

  assign word_bits = INIT_WORDS[24*int'(word_d) +: 24];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    half_d  = half_q;
    word_d  = word_q;
    rly_d   = rly_q;
    full_d  = full_q;
    set_d   = set_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start || relay_req) begin
          set_d  = {ch2_hg, ch1_hg, ch2_ac, ch1_ac};
          full_d = start;
          word_d = '0;
          rly_d  = '0;
          state_d = start ? CS_SETUP : RLY_PULSE;
        end
      end
      CS_SETUP: if (cnt_q == DIV_LAST) begin
        state_d = SHIFT;
        cnt_d   = '0;
        bit_d   = 5'd23;
        half_d  = 1'b0;
      end
      SHIFT: if (cnt_q == DIV_LAST) begin
        cnt_d  = '0;
        half_d = ~half_q;
        if (half_q) begin
          if (bit_q == 5'd0) state_d = CS_HOLD;
          else bit_d = bit_q - 5'd1;
        end
      end
      CS_HOLD: if (cnt_q == DIV_LAST) begin
        state_d = CS_GAP;
        cnt_d   = '0;
      end
      CS_GAP: if (cnt_q == DIV_LAST) begin
        cnt_d = '0;
        if (word_q == WORD_LAST) begin
          state_d = RLY_PULSE;
          rly_d   = '0;
        end else begin
          state_d = CS_SETUP;
          word_d  = word_q + WW'(1);
        end
      end
      RLY_PULSE: if (cnt_q == PULSE_LAST) begin
        state_d = RLY_GAP;
        cnt_d   = '0;
      end
      RLY_GAP: if (cnt_q == GAP_LAST) begin
        cnt_d = '0;
        if (rly_q == 2'd3) begin
          state_d = IDLE;
          if (full_q) done_d = 1'b1;
        end else begin
          state_d = RLY_PULSE;
          rly_d   = rly_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next-state so they register in step with it.
  always_comb begin
    busy_d = (state_d != IDLE);
    csb_d  = !(state_d inside {CS_SETUP, SHIFT, CS_HOLD});
    sclk_d = (state_d == SHIFT) && half_d;
    sdio_d = 1'b0;
    h_d    = '0;
    l_d    = '0;
    comh_d = 1'b0;
    coml_d = 1'b0;
    unique case (1'b1)
      state_d == CS_SETUP: sdio_d = word_bits[23];
      state_d == SHIFT:    sdio_d = word_bits[bit_d];
      state_d == CS_HOLD:  sdio_d = sdio_q;
      state_d == RLY_PULSE: begin
        h_d[rly_d] = set_d[rly_d];
        l_d[rly_d] = ~set_d[rly_d];
        coml_d     = set_d[rly_d];
        comh_d     = ~set_d[rly_d];
      end
      default: ;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (ext_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      half_q  <= 1'b0;
      word_q  <= '0;
      rly_q   <= '0;
      full_q  <= 1'b0;
      set_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      csb_q   <= 1'b1;
      sclk_q  <= 1'b0;
      sdio_q  <= 1'b0;
      h_q     <= '0;
      l_q     <= '0;
      comh_q  <= 1'b0;
      coml_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      half_q  <= half_d;
      word_q  <= word_d;
      rly_q   <= rly_d;
      full_q  <= full_d;
      set_q   <= set_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      csb_q   <= csb_d;
      sclk_q  <= sclk_d;
      sdio_q  <= sdio_d;
      h_q     <= h_d;
      l_q     <= l_d;
      comh_q  <= comh_d;
      coml_q  <= coml_d;
    end
  end

  assign busy       = busy_q;
  assign cfg_done   = done_q;
  assign csb        = csb_q;
  assign sclk       = sclk_q;
  assign sdio       = sdio_q;
  assign sc1_ac_h   = h_q[0];
  assign sc1_ac_l   = l_q[0];
  assign sc2_ac_h   = h_q[1];
  assign sc2_ac_l   = l_q[1];
  assign sc1_gain_h = h_q[2];
  assign sc1_gain_l = l_q[2];
  assign sc2_gain_h = h_q[3];
  assign sc2_gain_l = l_q[3];
  assign com_sc_h   = comh_q;
  assign com_sc_l   = coml_q;

endmodule

// File: tb/tb_zmod_scope_cfg_seq.sv
// Bench for zmod_scope_cfg_seq: SPI decoder and relay-pulse monitor
// compared against a table/rule model of the configuration sequence.
module tb_zmod_scope_cfg_seq;

  localparam int CLK_DIV = 2;
  localparam int RP      = 8;
  localparam int RG      = 4;
  localparam int FULL_CYC = 4 * 51 * CLK_DIV + 4 * (RP + RG);
  localparam int RLY_CYC  = 4 * (RP + RG);
  localparam logic [23:0] EXP_W [4] =
    '{24'h00003C, 24'h000800, 24'h001401, 24'h00FF01};

  logic mclk = 1'b0;
  logic ext_rst = 1'b1;
  logic start = 1'b0, relay_req = 1'b0;
  logic ch1_ac = 1'b0, ch2_ac = 1'b0, ch1_hg = 1'b0, ch2_hg = 1'b0;
  logic busy, cfg_done, csb, sclk, sdio;
  logic sc1_ac_h, sc1_ac_l, sc2_ac_h, sc2_ac_l;
  logic sc1_gain_h, sc1_gain_l, sc2_gain_h, sc2_gain_l;
  logic com_sc_h, com_sc_l;
  logic [9:0] rv;

  int checks = 0;
  int passed = 0;
  logic model_done = 1'b0;

  always #5 mclk = ~mclk;

  zmod_scope_cfg_seq #(
    .CLK_DIV(CLK_DIV), .RELAY_PULSE(RP), .RELAY_GAP(RG)
  ) dut (
    .mclk(mclk), .ext_rst(ext_rst), .start(start), .relay_req(relay_req),
    .ch1_ac(ch1_ac), .ch2_ac(ch2_ac), .ch1_hg(ch1_hg), .ch2_hg(ch2_hg),
    .busy(busy), .cfg_done(cfg_done), .csb(csb), .sclk(sclk), .sdio(sdio),
    .sc1_ac_h(sc1_ac_h), .sc1_ac_l(sc1_ac_l),
    .sc2_ac_h(sc2_ac_h), .sc2_ac_l(sc2_ac_l),
    .sc1_gain_h(sc1_gain_h), .sc1_gain_l(sc1_gain_l),
    .sc2_gain_h(sc2_gain_h), .sc2_gain_l(sc2_gain_l),
    .com_sc_h(com_sc_h), .com_sc_l(com_sc_l)
  );

  assign rv = {sc1_ac_h, sc1_ac_l, sc2_ac_h, sc2_ac_l,
               sc1_gain_h, sc1_gain_l, sc2_gain_h, sc2_gain_l,
               com_sc_h, com_sc_l};

  // Monitor: decodes SPI words and records relay-pin runs.
  logic mon_on = 1'b0;
  logic [23:0] word_q [$];
  int edge_q [$], low_q [$], gap_q [$];
  logic [9:0] seg_v [$];
  int seg_n [$];
  int csb_falls = 0, sdio_viol = 0, inv_viol = 0;

  initial begin
    logic p_csb, p_sclk, p_sdio;
    logic [9:0] p_rv;
    logic [31:0] sh;
    int nedge, lowlen, highlen, runlen;
    p_csb = 1'b1; p_sclk = 1'b0; p_sdio = 1'b0; p_rv = '0;
    sh = '0; nedge = 0; lowlen = 0; highlen = 0; runlen = 0;
    forever begin
      @(negedge mclk);
      if (mon_on) begin
        if (!p_sclk && sclk && !csb) begin
          sh = {sh[30:0], sdio};
          nedge++;
        end
        if (sclk && (sdio !== p_sdio)) sdio_viol++;
        if (!csb && p_csb) begin
          gap_q.push_back(highlen);
          csb_falls++;
          lowlen = 0; nedge = 0; sh = '0;
        end
        if (csb && !p_csb) begin
          word_q.push_back(sh[23:0]);
          edge_q.push_back(nedge);
          low_q.push_back(lowlen);
          highlen = 0;
        end
        if (csb) highlen++;
        else lowlen++;
        if (rv !== p_rv) begin
          seg_v.push_back(p_rv);
          seg_n.push_back(runlen);
          runlen = 0;
        end
        runlen++;
        if ($countones(rv[9:2]) > 1 || (rv[1] && rv[0])) inv_viol++;
        p_csb = csb; p_sclk = sclk; p_sdio = sdio; p_rv = rv;
      end
    end
  end

  function automatic logic [9:0] exp_rv(input int k, input logic [3:0] set);
    logic [9:0] v;
    v = '0;
    if (set[k]) begin
      v[9-2*k] = 1'b1;
      v[0] = 1'b1;
    end else begin
      v[8-2*k] = 1'b1;
      v[1] = 1'b1;
    end
    return v;
  endfunction

  task automatic drive_req(input bit s, input bit r, input logic [3:0] ch,
                           input bit spam, output int bcyc, output bit rose,
                           output bit tmo, output logic done_pre,
                           output logic done_fall);
    @(negedge mclk);
    {ch2_hg, ch1_hg, ch2_ac, ch1_ac} = ch;
    start = s;
    relay_req = r;
    @(negedge mclk);
    start = 1'b0;
    relay_req = 1'b0;
    rose = (busy === 1'b1);
    bcyc = 0;
    tmo = 1'b1;
    done_pre = cfg_done;
    done_fall = 1'bx;
    for (int i = 0; i < 3000; i++) begin
      if (busy !== 1'b1) begin
        tmo = 1'b0;
        done_fall = cfg_done;
        break;
      end
      bcyc++;
      done_pre = cfg_done;
      if (spam) begin
        start = ($urandom_range(0, 7) == 0);
        relay_req = ($urandom_range(0, 7) == 0);
        {ch2_hg, ch1_hg, ch2_ac, ch1_ac} = 4'($urandom);
      end
      @(negedge mclk);
    end
    start = 1'b0;
    relay_req = 1'b0;
  endtask

  task automatic test_reset();
    ext_rst = 1'b1;
    repeat (3) @(negedge mclk);
    checks++; if (csb !== 1'b1) $display("FAIL reset_csb: got %b expected 1", csb); else passed++;
    checks++; if (sclk !== 1'b0) $display("FAIL reset_sclk: got %b expected 0", sclk); else passed++;
    checks++; if (sdio !== 1'b0) $display("FAIL reset_sdio: got %b expected 0", sdio); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    checks++; if (cfg_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", cfg_done); else passed++;
    checks++; if (rv !== 10'd0) $display("FAIL reset_relays: got %b expected 0", rv); else passed++;
    ext_rst = 1'b0;
    mon_on = 1'b1;
    repeat (2) @(negedge mclk);
  endtask

  task automatic test_relay_before_cfg();
    int bcyc, f0, bs;
    bit rose, tmo;
    logic dp, df;
    logic [3:0] ch;
    ch = 4'($urandom);
    f0 = csb_falls;
    bs = seg_v.size();
    drive_req(1'b0, 1'b1, ch, 1'b0, bcyc, rose, tmo, dp, df);
    checks++; if (!rose || tmo) $display("FAIL pre_busy: rose %b timeout %b expected 1/0", rose, tmo); else passed++;
    checks++; if (bcyc != RLY_CYC) $display("FAIL pre_len: got %0d expected %0d", bcyc, RLY_CYC); else passed++;
    checks++; if (df !== model_done) $display("FAIL pre_done: got %b expected %b", df, model_done); else passed++;
    checks++; if (csb_falls != f0) $display("FAIL pre_csb: got %0d expected %0d", csb_falls - f0, 0); else passed++;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (seg_v[bs+1+2*k] !== exp_rv(k, ch) || seg_n[bs+1+2*k] != RP)
        $display("FAIL pre_pulse%0d: got %b/%0d expected %b/%0d", k, seg_v[bs+1+2*k], seg_n[bs+1+2*k], exp_rv(k, ch), RP);
      else passed++;
    end
  endtask

  task automatic test_full_start();
    int bcyc, bw, bg, bs, f0, v0, i0;
    bit rose, tmo;
    logic dp, df;
    logic [3:0] ch;
    ch = 4'b0101;
    bw = word_q.size(); bg = gap_q.size(); bs = seg_v.size();
    f0 = csb_falls; v0 = sdio_viol; i0 = inv_viol;
    drive_req(1'b1, 1'b0, ch, 1'b0, bcyc, rose, tmo, dp, df);
    model_done = 1'b1;
    checks++; if (!rose || tmo) $display("FAIL full_busy: rose %b timeout %b expected 1/0", rose, tmo); else passed++;
    checks++; if (bcyc != FULL_CYC) $display("FAIL full_len: got %0d expected %0d", bcyc, FULL_CYC); else passed++;
    checks++; if (dp !== 1'b0 || df !== 1'b1) $display("FAIL full_done_edge: got %b->%b expected 0->1", dp, df); else passed++;
    checks++; if (csb_falls - f0 != 4 || word_q.size() < bw + 4) $display("FAIL full_nwords: got %0d expected 4", csb_falls - f0); else passed++;
    for (int k = 0; k < 4; k++) begin
      checks++; if (word_q[bw+k] !== EXP_W[k]) $display("FAIL full_word%0d: got %06h expected %06h", k, word_q[bw+k], EXP_W[k]); else passed++;
      checks++; if (edge_q[bw+k] != 24) $display("FAIL full_edges%0d: got %0d expected 24", k, edge_q[bw+k]); else passed++;
      checks++; if (low_q[bw+k] != 50 * CLK_DIV) $display("FAIL full_csblow%0d: got %0d expected %0d", k, low_q[bw+k], 50 * CLK_DIV); else passed++;
      if (k > 0) begin
        checks++; if (gap_q[bg+k] != CLK_DIV) $display("FAIL full_csbgap%0d: got %0d expected %0d", k, gap_q[bg+k], CLK_DIV); else passed++;
      end
    end
    checks++; if (sdio_viol != v0) $display("FAIL full_sdio_stable: got %0d changes expected 0", sdio_viol - v0); else passed++;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (seg_v[bs+1+2*k] !== exp_rv(k, ch) || seg_n[bs+1+2*k] != RP)
        $display("FAIL full_pulse%0d: got %b/%0d expected %b/%0d", k, seg_v[bs+1+2*k], seg_n[bs+1+2*k], exp_rv(k, ch), RP);
      else passed++;
      if (k < 3) begin
        checks++;
        if (seg_v[bs+2+2*k] !== 10'd0 || seg_n[bs+2+2*k] != RG)
          $display("FAIL full_gap%0d: got %b/%0d expected 0/%0d", k, seg_v[bs+2+2*k], seg_n[bs+2+2*k], RG);
        else passed++;
      end
    end
    checks++; if (inv_viol != i0) $display("FAIL full_one_coil: got %0d violations expected 0", inv_viol - i0); else passed++;
  endtask

  task automatic test_relay_only();
    int bcyc, f0, bs;
    bit rose, tmo;
    logic dp, df;
    f0 = csb_falls;
    bs = seg_v.size();
    drive_req(1'b0, 1'b1, 4'hF, 1'b1, bcyc, rose, tmo, dp, df);
    checks++; if (!rose || tmo) $display("FAIL rly_busy: rose %b timeout %b expected 1/0", rose, tmo); else passed++;
    checks++; if (bcyc != RLY_CYC) $display("FAIL rly_len: got %0d expected %0d", bcyc, RLY_CYC); else passed++;
    checks++; if (df !== model_done) $display("FAIL rly_done: got %b expected %b", df, model_done); else passed++;
    checks++; if (csb_falls != f0) $display("FAIL rly_no_spi: got %0d words expected 0", csb_falls - f0); else passed++;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (seg_v[bs+1+2*k] !== exp_rv(k, 4'hF) || seg_n[bs+1+2*k] != RP)
        $display("FAIL rly_pulse%0d: got %b/%0d expected %b/%0d", k, seg_v[bs+1+2*k], seg_n[bs+1+2*k], exp_rv(k, 4'hF), RP);
      else passed++;
    end
    repeat (20) @(negedge mclk);
    checks++; if (busy !== 1'b0) $display("FAIL rly_no_requeue: got busy %b expected 0", busy); else passed++;
  endtask

  task automatic test_simultaneous();
    int bcyc, bw, f0, bs;
    bit rose, tmo;
    logic dp, df;
    logic [3:0] ch;
    ch = 4'($urandom);
    bw = word_q.size(); f0 = csb_falls; bs = seg_v.size();
    drive_req(1'b1, 1'b1, ch, 1'b0, bcyc, rose, tmo, dp, df);
    model_done = 1'b1;
    repeat (30) @(negedge mclk);
    checks++; if (bcyc != FULL_CYC || tmo) $display("FAIL both_len: got %0d expected %0d", bcyc, FULL_CYC); else passed++;
    checks++; if (csb_falls - f0 != 4) $display("FAIL both_once: got %0d words expected 4", csb_falls - f0); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL both_idle: got busy %b expected 0", busy); else passed++;
    checks++; if (word_q[bw+3] !== EXP_W[3]) $display("FAIL both_word3: got %06h expected %06h", word_q[bw+3], EXP_W[3]); else passed++;
    checks++; if (df !== model_done) $display("FAIL both_done: got %b expected %b", df, model_done); else passed++;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (seg_v[bs+1+2*k] !== exp_rv(k, ch))
        $display("FAIL both_pulse%0d: got %b expected %b", k, seg_v[bs+1+2*k], exp_rv(k, ch));
      else passed++;
    end
  endtask

  task automatic test_reset_mid_shift();
    int bcyc, bw, rises;
    bit rose, tmo, hit;
    logic dp, df, ps;
    @(negedge mclk);
    start = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    rises = 0; hit = 1'b0; ps = sclk;
    for (int i = 0; i < 2000; i++) begin
      if (!ps && sclk) rises++;
      ps = sclk;
      if (rises == 14) begin
        hit = 1'b1;
        break;
      end
      @(negedge mclk);
    end
    checks++; if (!hit) $display("FAIL mid_reach_bit10: got %0d rises expected 14", rises); else passed++;
    ext_rst = 1'b1;
    @(negedge mclk);
    ext_rst = 1'b0;
    model_done = 1'b0;
    checks++; if (csb !== 1'b1) $display("FAIL mid_csb: got %b expected 1", csb); else passed++;
    checks++; if (sclk !== 1'b0) $display("FAIL mid_sclk: got %b expected 0", sclk); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b expected 0", busy); else passed++;
    checks++; if (cfg_done !== 1'b0) $display("FAIL mid_done: got %b expected 0", cfg_done); else passed++;
    repeat (3) @(negedge mclk);
    checks++; if (busy !== 1'b0) $display("FAIL mid_no_resume: got busy %b expected 0", busy); else passed++;
    bw = word_q.size();
    drive_req(1'b1, 1'b0, 4'h0, 1'b0, bcyc, rose, tmo, dp, df);
    model_done = 1'b1;
    checks++; if (word_q[bw] !== EXP_W[0] || edge_q[bw] != 24) $display("FAIL mid_restart_word0: got %06h/%0d expected %06h/24", word_q[bw], edge_q[bw], EXP_W[0]); else passed++;
    checks++; if (bcyc != FULL_CYC || tmo) $display("FAIL mid_restart_len: got %0d expected %0d", bcyc, FULL_CYC); else passed++;
    checks++; if (df !== model_done) $display("FAIL mid_restart_done: got %b expected %b", df, model_done); else passed++;
  endtask

  task automatic test_random();
    int bcyc, f0, bs, ew;
    bit rose, tmo, s;
    logic dp, df;
    logic [3:0] ch;
    for (int it = 0; it < 4; it++) begin
      s = 1'($urandom_range(0, 1));
      ch = 4'($urandom);
      f0 = csb_falls;
      bs = seg_v.size();
      drive_req(s, !s, ch, 1'b1, bcyc, rose, tmo, dp, df);
      if (s) model_done = 1'b1;
      ew = s ? 4 : 0;
      checks++; if (bcyc != (s ? FULL_CYC : RLY_CYC) || tmo) $display("FAIL rnd%0d_len: got %0d expected %0d", it, bcyc, s ? FULL_CYC : RLY_CYC); else passed++;
      checks++; if (csb_falls - f0 != ew) $display("FAIL rnd%0d_words: got %0d expected %0d", it, csb_falls - f0, ew); else passed++;
      checks++; if (df !== model_done) $display("FAIL rnd%0d_done: got %b expected %b", it, df, model_done); else passed++;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (seg_v[bs+1+2*k] !== exp_rv(k, ch) || seg_n[bs+1+2*k] != RP)
          $display("FAIL rnd%0d_pulse%0d: got %b/%0d expected %b/%0d", it, k, seg_v[bs+1+2*k], seg_n[bs+1+2*k], exp_rv(k, ch), RP);
        else passed++;
      end
    end
    checks++; if (inv_viol != 0) $display("FAIL coil_exclusive: got %0d violations expected 0", inv_viol); else passed++;
    checks++; if (sdio_viol != 0) $display("FAIL sdio_stable_all: got %0d changes expected 0", sdio_viol); else passed++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_relay_before_cfg();
    test_full_start();
    test_relay_only();
    test_simultaneous();
    test_reset_mid_shift();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
